// File: rtl/fp_rnd_pipe.sv
// Two-stage IEEE-754 rounding/packing unit: stage 1 picks the rounding increment,
// stage 2 renormalises, detects overflow/underflow, applies special cases and packs.
module fp_rnd_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sig,
  input  logic [EXP_W+1:0]       in_expo,
  input  logic [MAN_W:0]         in_mant,
  input  logic [2:0]             in_grs,
  input  logic [2:0]             in_rm,
  input  logic                   in_snan,
  input  logic                   in_qnan,
  input  logic                   in_dbz,
  input  logic                   in_inf,
  input  logic                   in_zero,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic [4:0]             out_flags,
  output logic [4:0]             acc_flags,
  input  logic                   acc_clr
);

  localparam int RES_W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W+2:0] E_OVF = {3'b000, {EXP_W{1'b1}}};

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  logic             s1_v_q, s2_v_q;
  logic [MAN_W+1:0] s1_m_q, s1_m_d;
  logic [EXP_W+1:0] s1_e_q;
  logic             s1_sig_q;
  rm_e              s1_rm_q, s1_rm_d;
  logic             s1_nx_q, s1_nx_d;
  logic [4:0]       s1_tag_q;
  logic [RES_W-1:0] res_q, res_d;
  logic [4:0]       flg_q, flg_d;
  logic [4:0]       acc_q, acc_d;

  logic adv1, adv2, hs, inc;

  assign adv2     = ~s2_v_q | out_ready;
  assign adv1     = ~s1_v_q | adv2;
  assign in_ready = adv1;
  assign hs       = s2_v_q & out_ready;

  // Stage 1: rounding increment; reserved modes collapse to RNE here so stage 2 never sees them
  always_comb begin
    s1_rm_d = RM_RNE;
    if (in_rm <= 3'd4) s1_rm_d = rm_e'(in_rm);
    s1_nx_d = |in_grs;
    inc     = 1'b0;
    case (s1_rm_d)
      RM_RNE:  inc = in_grs[2] & (in_mant[0] | in_grs[1] | in_grs[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = in_sig & s1_nx_d;
      RM_RUP:  inc = ~in_sig & s1_nx_d;
      RM_RMM:  inc = in_grs[2];
      default: inc = 1'b0;
    endcase
    s1_m_d = {1'b0, in_mant} + {{(MAN_W+1){1'b0}}, inc};
  end

  // Stage 2: renormalise, overflow per rounding direction, specials last so they win
  logic [EXP_W+2:0] e2;
  logic [MAN_W-1:0] frac2;
  logic             uf2, to_inf;

  always_comb begin
    e2    = {1'b0, s1_e_q};
    frac2 = s1_m_q[MAN_W-1:0];
    if (s1_m_q[MAN_W+1]) begin
      frac2 = s1_m_q[MAN_W:1];
      e2    = {1'b0, s1_e_q} + {{(EXP_W+2){1'b0}}, 1'b1};
    end else if ((s1_e_q == '0) && s1_m_q[MAN_W]) begin
      e2 = {{(EXP_W+2){1'b0}}, 1'b1};
    end
    uf2    = s1_nx_q & (e2 == '0);
    to_inf = (s1_rm_q == RM_RNE) || (s1_rm_q == RM_RMM) ||
             ((s1_rm_q == RM_RUP) && !s1_sig_q) || ((s1_rm_q == RM_RDN) && s1_sig_q);

    res_d = {s1_sig_q, e2[EXP_W-1:0], frac2};
    flg_d = {3'b000, uf2, s1_nx_q};
    if (e2 >= E_OVF) begin
      flg_d = 5'b00101;
      if (to_inf) res_d = {s1_sig_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else        res_d = {s1_sig_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    end

    if (s1_tag_q[4]) begin
      res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flg_d = 5'b10000;
    end else if (s1_tag_q[3]) begin
      res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flg_d = 5'b00000;
    end else if (s1_tag_q[2]) begin
      res_d = {s1_sig_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_d = 5'b01000;
    end else if (s1_tag_q[1]) begin
      res_d = {s1_sig_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_d = 5'b00000;
    end else if (s1_tag_q[0]) begin
      res_d = {s1_sig_q, {(EXP_W+MAN_W){1'b0}}};
      flg_d = 5'b00000;
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (acc_clr)  acc_d = hs ? flg_q : 5'b00000;
    else if (hs)  acc_d = acc_q | flg_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      s1_m_q   <= '0;
      s1_e_q   <= '0;
      s1_sig_q <= 1'b0;
      s1_rm_q  <= RM_RNE;
      s1_nx_q  <= 1'b0;
      s1_tag_q <= '0;
      res_q    <= '0;
      flg_q    <= '0;
      acc_q    <= '0;
    end else begin
      if (flush) begin
        s1_v_q <= 1'b0;
        s2_v_q <= 1'b0;
      end else begin
        if (adv1) s1_v_q <= in_valid;
        if (adv2) s2_v_q <= s1_v_q;
      end
      if (adv1 && in_valid) begin
        s1_m_q   <= s1_m_d;
        s1_e_q   <= in_expo;
        s1_sig_q <= in_sig;
        s1_rm_q  <= s1_rm_d;
        s1_nx_q  <= s1_nx_d;
        s1_tag_q <= {in_snan, in_qnan, in_dbz, in_inf, in_zero};
      end
      if (adv2 && s1_v_q) begin
        res_q <= res_d;
        flg_q <= flg_d;
      end
      acc_q <= acc_d;
    end
  end

  assign out_valid  = s2_v_q;
  assign out_result = res_q;
  assign out_flags  = flg_q;
  assign acc_flags  = acc_q;

endmodule

// File: tb/tb_fp_rnd_pipe.sv
// Scoreboard bench for fp_rnd_pipe (binary32): driver pushes expected results,
// a negedge monitor pops them on every output handshake and tracks acc_flags.
module tb_fp_rnd_pipe;

  logic        clock, reset, flush, in_valid, in_ready, in_sig;
  logic [9:0]  in_expo;
  logic [23:0] in_mant;
  logic [2:0]  in_grs, in_rm;
  logic        in_snan, in_qnan, in_dbz, in_inf, in_zero;
  logic        out_valid, out_ready, acc_clr;
  logic [31:0] out_result;
  logic [4:0]  out_flags, acc_flags;

  fp_rnd_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_sig(in_sig), .in_expo(in_expo), .in_mant(in_mant), .in_grs(in_grs), .in_rm(in_rm),
    .in_snan(in_snan), .in_qnan(in_qnan), .in_dbz(in_dbz), .in_inf(in_inf), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .acc_flags(acc_flags), .acc_clr(acc_clr));

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         errs = 0;
  bit         rdy_rand = 0;
  logic [4:0] acc_m = '0;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: numeric rounding of the unbounded value, then range and special handling
  function automatic exp_t model(input logic sg, input logic [9:0] ex, input logic [23:0] mn,
                                 input logic [2:0] gr, input logic [2:0] rmv, input logic [4:0] tg);
    exp_t   x;
    int     r;
    longint m, e;
    bit     nx, inc, uf, to_inf;
    r  = (rmv > 3'd4) ? 0 : int'(rmv);
    nx = (gr != 3'b000);
    case (r)
      0:       inc = gr[2] && (mn[0] || gr[1] || gr[0]);
      1:       inc = 0;
      2:       inc = sg && nx;
      3:       inc = !sg && nx;
      default: inc = gr[2];
    endcase
    m = longint'(mn) + longint'(inc);
    e = longint'(ex);
    if (m >= 64'sd16777216) begin
      m = m / 2;
      e = e + 1;
    end else if (e == 0 && m >= 64'sd8388608) begin
      e = 1;
    end
    uf = nx && (e == 0);
    if (e >= 255) begin
      to_inf = (r == 0) || (r == 4) || (r == 3 && !sg) || (r == 2 && sg);
      x.res = {sg, to_inf ? 31'h7F800000 : 31'h7F7FFFFF};
      x.flg = 5'b00101;
    end else begin
      x.res = {sg, e[7:0], m[22:0]};
      x.flg = {3'b000, uf, nx};
    end
    if (tg[4])      begin x.res = 32'h7FC00000;          x.flg = 5'b10000; end
    else if (tg[3]) begin x.res = 32'h7FC00000;          x.flg = 5'b00000; end
    else if (tg[2]) begin x.res = {sg, 31'h7F800000};    x.flg = 5'b01000; end
    else if (tg[1]) begin x.res = {sg, 31'h7F800000};    x.flg = 5'b00000; end
    else if (tg[0]) begin x.res = {sg, 31'h00000000};    x.flg = 5'b00000; end
    return x;
  endfunction

  task automatic send(input logic sg, input logic [9:0] ex, input logic [23:0] mn, input logic [2:0] gr,
                      input logic [2:0] rmv, input logic [4:0] tg, input bit use_k,
                      input logic [31:0] k_res, input logic [4:0] k_flg);
    bit   acc;
    exp_t x;
    in_valid = 1; in_sig = sg; in_expo = ex; in_mant = mn; in_grs = gr; in_rm = rmv;
    {in_snan, in_qnan, in_dbz, in_inf, in_zero} = tg;
    acc = 0;
    for (int n = 0; n < 60 && !acc; n++) begin
      if (rdy_rand) begin
        out_ready = ($urandom_range(0, 3) != 0);
        acc_clr   = ($urandom_range(0, 15) == 0);
      end
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
    end
    if (!acc) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      if (use_k) begin x.res = k_res; x.flg = k_flg; end
      else x = model(sg, ex, mn, gr, rmv, tg);
      sb.push_back(x);
    end
    acc_clr = 0;
  endtask

  task automatic sendk(input logic sg, input logic [9:0] ex, input logic [23:0] mn, input logic [2:0] gr,
                       input logic [2:0] rmv, input logic [4:0] tg, input logic [31:0] k_res,
                       input logic [4:0] k_flg);
    send(sg, ex, mn, gr, rmv, tg, 1'b1, k_res, k_flg);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    in_valid  = 0;
    acc_clr   = 0;
    out_ready = 1;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (sb.size() > 0) begin
      chk("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    idle(2);
  endtask

  // Monitor: acc_flags is compared to the value the model predicted at the previous negedge
  initial begin
    bit         acc_ok;
    bit         hs;
    logic [4:0] ef;
    exp_t       e;
    acc_ok = 0;
    forever begin
      @(negedge clock);
      if (acc_ok) chk("acc_flags", {27'd0, acc_flags}, {27'd0, acc_m});
      hs = out_valid && out_ready && reset;
      ef = '0;
      if (hs) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", out_result, 32'hxxxxxxxx);
        end else begin
          e = sb.pop_front();
          chk("result", out_result, e.res);
          chk("flags", {27'd0, out_flags}, {27'd0, e.flg});
          ef = e.flg;
        end
      end
      if (!reset) begin
        acc_m  = '0;
        acc_ok = 1;
      end else if (acc_clr) acc_m = hs ? ef : 5'b00000;
      else if (hs) acc_m = acc_m | ef;
    end
  end

  initial begin
    logic [9:0]  ex;
    logic [23:0] mn;
    logic [4:0]  tg;
    int          cls;
    reset = 0; flush = 0; in_valid = 0; in_sig = 0; in_expo = '0; in_mant = '0; in_grs = '0;
    in_rm = '0; {in_snan, in_qnan, in_dbz, in_inf, in_zero} = '0; out_ready = 0; acc_clr = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_flags", {27'd0, out_flags}, 32'd0);
    chk("rst_acc_flags", {27'd0, acc_flags}, 32'd0);
    reset = 1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed vectors, back to back at full throughput
    out_ready = 1;
    sendk(0, 10'd127, 24'h800001, 3'b100, 3'd0, 5'd0, 32'h3F800002, 5'b00001);
    sendk(0, 10'd127, 24'hFFFFFF, 3'b110, 3'd0, 5'd0, 32'h40000000, 5'b00001);
    sendk(0, 10'd254, 24'hFFFFFF, 3'b111, 3'd1, 5'd0, 32'h7F7FFFFF, 5'b00001);
    sendk(0, 10'd254, 24'hFFFFFF, 3'b111, 3'd0, 5'd0, 32'h7F800000, 5'b00101);
    sendk(0, 10'd254, 24'hFFFFFF, 3'b111, 3'd2, 5'd0, 32'h7F7FFFFF, 5'b00001);
    sendk(1, 10'd255, 24'h800000, 3'b000, 3'd1, 5'd0, 32'hFF7FFFFF, 5'b00101);
    sendk(0, 10'd0,   24'h7FFFFF, 3'b111, 3'd3, 5'd0, 32'h00800000, 5'b00001);
    sendk(0, 10'd0,   24'h000010, 3'b001, 3'd1, 5'd0, 32'h00000010, 5'b00011);
    sendk(1, 10'd300, 24'h812345, 3'b000, 3'd1, 5'd0, 32'hFF7FFFFF, 5'b00101);
    sendk(0, 10'd127, 24'h800001, 3'b100, 3'd6, 5'd0, 32'h3F800002, 5'b00001);
    sendk(1, 10'd127, 24'h800000, 3'b100, 3'd4, 5'd0, 32'hBF800001, 5'b00001);
    sendk(1, 10'd5,   24'h812345, 3'b111, 3'd0, 5'b11111, 32'h7FC00000, 5'b10000);
    sendk(1, 10'd5,   24'h812345, 3'b000, 3'd0, 5'b01111, 32'h7FC00000, 5'b00000);
    sendk(1, 10'd5,   24'h812345, 3'b111, 3'd0, 5'b00111, 32'hFF800000, 5'b01000);
    sendk(0, 10'd5,   24'h812345, 3'b000, 3'd0, 5'b00011, 32'h7F800000, 5'b00000);
    sendk(1, 10'd5,   24'h812345, 3'b111, 3'd0, 5'b00001, 32'h80000000, 5'b00000);
    drain();

    // Backpressure: the third op must wait while the consumer stalls
    out_ready = 0;
    send(0, 10'd100, 24'h812345, 3'b101, 3'd0, 5'd0, 0, '0, '0);
    send(1, 10'd101, 24'hABCDEF, 3'b011, 3'd2, 5'd0, 0, '0, '0);
    in_valid = 1; in_expo = 10'd102; in_mant = 24'hC00001; in_grs = 3'b110; in_rm = 3'd3; in_sig = 0;
    repeat (4) begin
      @(negedge clock);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clock);
      #1;
    end
    out_ready = 1;
    send(0, 10'd102, 24'hC00001, 3'b110, 3'd3, 5'd0, 0, '0, '0);
    drain();

    // Sticky flags and acc_clr
    out_ready = 0; acc_clr = 1;
    idle(1);
    acc_clr = 0;
    out_ready = 1;
    sendk(0, 10'd1, 24'h800000, 3'b000, 3'd0, 5'b10000, 32'h7FC00000, 5'b10000);
    sendk(0, 10'd1, 24'h800000, 3'b000, 3'd0, 5'b00100, 32'h7F800000, 5'b01000);
    drain();
    chk("sticky_acc", {27'd0, acc_flags}, 32'h18);
    out_ready = 0;
    sendk(0, 10'd127, 24'h800001, 3'b100, 3'd0, 5'd0, 32'h3F800002, 5'b00001);
    in_valid = 0;
    for (int n = 0; n < 10 && !out_valid; n++) begin
      @(posedge clock);
      #1;
    end
    acc_clr = 1; out_ready = 1;
    @(posedge clock);
    #1;
    acc_clr = 0; out_ready = 0;
    chk("clr_with_hs_acc", {27'd0, acc_flags}, 32'h01);
    drain();

    // Flush with two ops in flight, then flush dropping a newly accepted op
    out_ready = 0;
    send(0, 10'd120, 24'h900000, 3'b001, 3'd0, 5'd0, 0, '0, '0);
    send(0, 10'd121, 24'h900000, 3'b001, 3'd0, 5'd0, 0, '0, '0);
    in_valid = 0; flush = 1;
    @(posedge clock);
    #1;
    flush = 0;
    sb.delete();
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1;
    in_valid = 1; flush = 1; in_expo = 10'd50;
    @(posedge clock);
    #1;
    in_valid = 0; flush = 0;
    repeat (3) begin
      @(posedge clock);
      #1;
      chk("flush_drop_valid", {31'd0, out_valid}, 32'd0);
    end

    // Reset with ops in flight
    out_ready = 0;
    send(1, 10'd130, 24'hA00000, 3'b010, 3'd4, 5'd0, 0, '0, '0);
    send(1, 10'd131, 24'hA00000, 3'b010, 3'd4, 5'd0, 0, '0, '0);
    in_valid = 0; reset = 0;
    idle(2);
    sb.delete();
    reset = 1;
    chk("rst2_out_result", out_result, 32'd0);
    chk("rst2_acc", {27'd0, acc_flags}, 32'd0);
    out_ready = 1;
    repeat (3) begin
      @(posedge clock);
      #1;
      chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    end

    // Randomised traffic with random backpressure and acc_clr
    rdy_rand = 1;
    for (int i = 0; i < 400; i++) begin
      cls = $urandom_range(0, 3);
      case (cls)
        0:       ex = 10'($urandom_range(0, 1));
        1:       ex = 10'($urandom_range(250, 258));
        2:       ex = 10'($urandom_range(1, 253));
        default: ex = 10'($urandom_range(0, 1023));
      endcase
      mn = 24'($urandom);
      if ($urandom_range(0, 3) == 0) mn = 24'hFFFFFF;
      else if (ex != 0 && $urandom_range(0, 3) != 0) mn[23] = 1'b1;
      tg = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
      send(1'($urandom), ex, mn, 3'($urandom), 3'($urandom), tg, 0, '0, '0);
      if ($urandom_range(0, 4) == 0) begin
        out_ready = ($urandom_range(0, 1) != 0);
        idle(1);
      end
    end
    rdy_rand = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
